// File: rtl/apb_master_ctrl.sv
// APB3 master controller: turns a command port into IDLE/SETUP/ACCESS bus
// cycles toward two slaves selected by the address MSB, with wait states,
// slave-error reporting and an optional wait-state timeout.
module apb_master_ctrl #(
    parameter int unsigned AW      = 9,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    input  logic          transfer,
    input  logic          read_write,
    input  logic [AW-1:0] apb_write_paddr,
    input  logic [DW-1:0] apb_write_data,
    input  logic [AW-1:0] apb_read_paddr,
    output logic [DW-1:0] apb_read_data_out,
    output logic          xfer_done,
    output logic          xfer_err,
    output logic          psel1,
    output logic          psel2,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr
);

    localparam int unsigned     CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0]   CNT_MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] wait_cnt, wait_cnt_d;

    logic          accept;
    logic          complete;
    logic          abort;
    logic          timeout_hit;

    logic [DW-1:0] rdata_d;
    logic          done_d, err_d;
    logic          psel1_d, psel2_d, penable_d, pwrite_d;
    logic [AW-1:0] paddr_d;
    logic [DW-1:0] pwdata_d;

    // The counter holds the number of wait edges already seen, so the abort
    // fires on the TIMEOUT-th low-pready edge in ACCESS.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);
    assign complete    = (state == ACCESS) && pready;
    assign abort       = (state == ACCESS) && !pready && timeout_hit;
    assign accept      = transfer && ((state == IDLE) || complete);

    // State and all output registers, synchronous active-low reset
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            apb_read_data_out <= '0;
            xfer_done         <= 1'b0;
            xfer_err          <= 1'b0;
            psel1             <= 1'b0;
            psel2             <= 1'b0;
            penable           <= 1'b0;
            pwrite            <= 1'b0;
            paddr             <= '0;
            pwdata            <= '0;
        end else begin
            state             <= state_d;
            wait_cnt          <= wait_cnt_d;
            apb_read_data_out <= rdata_d;
            xfer_done         <= done_d;
            xfer_err          <= err_d;
            psel1             <= psel1_d;
            psel2             <= psel2_d;
            penable           <= penable_d;
            pwrite            <= pwrite_d;
            paddr             <= paddr_d;
            pwdata            <= pwdata_d;
        end
    end

    // Next-state logic: timeout only considered while pready is low
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (transfer) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (pready)           state_d = transfer ? SETUP : IDLE;
                else if (timeout_hit) state_d = IDLE;
                else                  state_d = ACCESS;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, command latch and wait counter
    always_comb begin
        paddr_d    = paddr;
        pwrite_d   = pwrite;
        pwdata_d   = pwdata;
        rdata_d    = apb_read_data_out;
        wait_cnt_d = wait_cnt;

        if (accept) begin
            pwrite_d = ~read_write;
            paddr_d  = read_write ? apb_read_paddr : apb_write_paddr;
            if (!read_write) pwdata_d = apb_write_data;
        end

        if (complete && !pwrite && !pslverr) rdata_d = prdata;

        if (state == SETUP) begin
            wait_cnt_d = '0;
        end else if ((state == ACCESS) && !pready && (wait_cnt != CNT_MAX)) begin
            wait_cnt_d = wait_cnt + 1'b1;
        end

        // Selects are derived from the address being latched this edge so a
        // back-to-back transfer switches slaves right at its SETUP cycle.
        psel1_d   = (state_d != IDLE) && !paddr_d[AW-1];
        psel2_d   = (state_d != IDLE) &&  paddr_d[AW-1];
        penable_d = (state_d == ACCESS);
        done_d    = complete || abort;
        err_d     = (complete && pslverr) || abort;
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: one instance with default TIMEOUT and
// one with TIMEOUT = 4, both driven by the same command/slave stimulus.
module tb_apb_master_ctrl;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          transfer;
    logic          read_write;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [AW-1:0] apb_read_paddr;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    logic [DW-1:0] d_rdata, t_rdata;
    logic          d_done, t_done, d_err, t_err;
    logic          d_psel1, t_psel1, d_psel2, t_psel2;
    logic          d_penable, t_penable, d_pwrite, t_pwrite;
    logic [AW-1:0] d_paddr, t_paddr;
    logic [DW-1:0] d_pwdata, t_pwdata;

    int vectors    = 0;
    int miscompares = 0;

    always #5 pclk = ~pclk;

    apb_master_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .pclk(pclk), .presetn(presetn), .transfer(transfer), .read_write(read_write),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_read_paddr(apb_read_paddr), .apb_read_data_out(d_rdata),
        .xfer_done(d_done), .xfer_err(d_err), .psel1(d_psel1), .psel2(d_psel2),
        .penable(d_penable), .pwrite(d_pwrite), .paddr(d_paddr), .pwdata(d_pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_master_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut_to (
        .pclk(pclk), .presetn(presetn), .transfer(transfer), .read_write(read_write),
        .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
        .apb_read_paddr(apb_read_paddr), .apb_read_data_out(t_rdata),
        .xfer_done(t_done), .xfer_err(t_err), .psel1(t_psel1), .psel2(t_psel2),
        .penable(t_penable), .pwrite(t_pwrite), .paddr(t_paddr), .pwdata(t_pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        presetn = 1'b0; transfer = 1'b0; read_write = 1'b0;
        apb_write_paddr = '0; apb_write_data = '0; apb_read_paddr = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_psel1",   d_psel1,   0);
        chk("rst_psel2",   d_psel2,   0);
        chk("rst_penable", d_penable, 0);
        chk("rst_pwrite",  d_pwrite,  0);
        chk("rst_paddr",   d_paddr,   0);
        chk("rst_pwdata",  d_pwdata,  0);
        chk("rst_rdata",   d_rdata,   0);
        chk("rst_done",    d_done,    0);
        chk("rst_err",     d_err,     0);
        presetn = 1'b1;
        tick();

        // Write 0xC3 to slave 1 at 0x05A, no wait states
        transfer = 1'b1; read_write = 1'b0;
        apb_write_paddr = 9'h05A; apb_write_data = 8'hC3; pready = 1'b1;
        tick();
        transfer = 1'b0;
        chk("wr_setup_psel1",   d_psel1,   1);
        chk("wr_setup_psel2",   d_psel2,   0);
        chk("wr_setup_penable", d_penable, 0);
        chk("wr_paddr",         d_paddr,   9'h05A);
        chk("wr_pwdata",        d_pwdata,  8'hC3);
        chk("wr_pwrite",        d_pwrite,  1);
        chk("wr_setup_done",    d_done,    0);
        tick();
        chk("wr_acc_psel1",   d_psel1,   1);
        chk("wr_acc_penable", d_penable, 1);
        chk("wr_acc_psel2",   d_psel2,   0);
        tick();
        chk("wr_done",       d_done,    1);
        chk("wr_err",        d_err,     0);
        chk("wr_end_psel1",  d_psel1,   0);
        chk("wr_end_penable",d_penable, 0);
        chk("wr_paddr_hold", d_paddr,   9'h05A);
        tick();
        chk("wr_done_pulse", d_done, 0);

        // Read from slave 2 at 0x1F0 with 3 wait states
        transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h1F0; pready = 1'b0;
        tick();
        transfer = 1'b0;
        chk("rd_psel2",   d_psel2,  1);
        chk("rd_psel1",   d_psel1,  0);
        chk("rd_pwrite",  d_pwrite, 0);
        chk("rd_paddr",   d_paddr,  9'h1F0);
        chk("rd_pwdata_hold", d_pwdata, 8'hC3);
        tick();
        chk("rd_penable", d_penable, 1);
        tick(); chk("rd_wait1_done", d_done, 0);
        tick(); chk("rd_wait2_done", d_done, 0);
        tick(); chk("rd_wait3_done", d_done, 0);
        chk("rd_wait3_penable", d_penable, 1);
        chk("rd_wait3_to_done", t_done, 0);
        pready = 1'b1; prdata = 8'h7E;
        tick();
        chk("rd_done",   d_done,  1);
        chk("rd_err",    d_err,   0);
        chk("rd_data",   d_rdata, 8'h7E);
        chk("rd_to_done_last_wait", t_done, 1);
        chk("rd_to_err_last_wait",  t_err,  0);
        chk("rd_to_data",           t_rdata, 8'h7E);
        prdata = 8'h00;
        tick();
        chk("rd_done_pulse", d_done, 0);

        // Slave error on read: data must not update
        transfer = 1'b1; read_write = 1'b1; apb_read_paddr = 9'h0AB;
        pready = 1'b1; pslverr = 1'b1; prdata = 8'hAA;
        tick();
        transfer = 1'b0;
        tick();
        tick();
        chk("se_done",  d_done,  1);
        chk("se_err",   d_err,   1);
        chk("se_data",  d_rdata, 8'h7E);
        pslverr = 1'b0;
        tick();
        chk("se_done_pulse", d_done, 0);
        chk("se_err_pulse",  d_err,  0);

        // Back-to-back: write 0x010 then read 0x110
        transfer = 1'b1; read_write = 1'b0;
        apb_write_paddr = 9'h010; apb_write_data = 8'h5A; pready = 1'b1;
        tick();
        chk("bb_s1_psel1", d_psel1, 1);
        tick();
        chk("bb_a1_penable", d_penable, 1);
        read_write = 1'b1; apb_read_paddr = 9'h110; prdata = 8'h3C;
        tick();
        chk("bb_done1",     d_done,    1);
        chk("bb_s2_penable",d_penable, 0);
        chk("bb_s2_psel1",  d_psel1,   0);
        chk("bb_s2_psel2",  d_psel2,   1);
        chk("bb_s2_paddr",  d_paddr,   9'h110);
        chk("bb_s2_pwrite", d_pwrite,  0);
        chk("bb_s2_pwdata", d_pwdata,  8'h5A);
        chk("bb_data_keep", d_rdata,   8'h7E);
        tick();
        transfer = 1'b0;
        chk("bb_a2_penable", d_penable, 1);
        chk("bb_a2_done",    d_done,    0);
        tick();
        chk("bb_done2",   d_done,  1);
        chk("bb_data2",   d_rdata, 8'h3C);
        chk("bb_end_psel2", d_psel2, 0);
        tick();

        // Timeout on the TIMEOUT=4 instance with transfer held high
        transfer = 1'b1; read_write = 1'b0;
        apb_write_paddr = 9'h033; apb_write_data = 8'h11; pready = 1'b0;
        tick();
        tick();
        chk("to_acc_penable", t_penable, 1);
        tick(); chk("to_w1_done", t_done, 0);
        tick(); chk("to_w2_done", t_done, 0);
        tick(); chk("to_w3_done", t_done, 0);
        tick();
        chk("to_abort_done",    t_done,    1);
        chk("to_abort_err",     t_err,     1);
        chk("to_abort_psel1",   t_psel1,   0);
        chk("to_abort_penable", t_penable, 0);
        chk("to_abort_data",    t_rdata,   8'h3C);
        chk("to_long_done",     d_done,    0);
        chk("to_long_penable",  d_penable, 1);
        tick();
        chk("to_restart_psel1",   t_psel1,   1);
        chk("to_restart_penable", t_penable, 0);
        chk("to_restart_done",    t_done,    0);

        // Reset while the default instance waits in ACCESS
        transfer = 1'b0; presetn = 1'b0;
        tick();
        chk("mr_psel1",   d_psel1,   0);
        chk("mr_psel2",   d_psel2,   0);
        chk("mr_penable", d_penable, 0);
        chk("mr_paddr",   d_paddr,   0);
        chk("mr_pwdata",  d_pwdata,  0);
        chk("mr_rdata",   d_rdata,   0);
        chk("mr_done",    d_done,    0);
        presetn = 1'b1;
        tick();
        chk("mr_no_done", d_done, 0);
        transfer = 1'b1; read_write = 1'b0;
        apb_write_paddr = 9'h1C4; apb_write_data = 8'h99; pready = 1'b1;
        tick();
        transfer = 1'b0;
        chk("mr_new_psel2",  d_psel2,  1);
        chk("mr_new_pwdata", d_pwdata, 8'h99);
        tick();
        tick();
        chk("mr_new_done", d_done, 1);
        chk("mr_new_err",  d_err,  0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

endmodule
